// File: rtl/hdlc_rx_deframer_pkg.sv
// hdlc_pkg: constants and types shared by the HDLC transmit and receive paths.
//   FLAG_PATTERN : frame delimiter octet 0x7E
//   STUFF_RUN    : run of 1s after which the transmitter inserts a 0
//   ABORT_RUN    : run of 1s that signals an abort
//   rx_state_t   : receive deframer states
package hdlc_pkg;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam logic [2:0] STUFF_RUN    = 3'd5;
  localparam logic [2:0] ABORT_RUN    = 3'd7;

  typedef enum logic [1:0] {
    HUNT,
    FLAG,
    FRAME
  } rx_state_t;

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if: serial receive line plus deframer event/data outputs.
//   Rx, RxEN         : serial bit and its sampling strobe
//   Rx_FlagDetect    : flag pulse
//   Rx_AbortDetect   : in-frame abort pulse
//   Rx_ValidFrame    : frame body in progress
//   Rx_StartFrame    : first byte of frame pulse
//   Rx_NewByte       : Rx_Data valid pulse
//   Rx_Data          : assembled byte
//   Rx_EndFrame      : closing flag pulse
//   Rx_FrameError    : bad frame, with Rx_EndFrame
// master = line driver / byte consumer, slave = deframer.
interface hdlc_rx_deframer_if;

  logic       Rx;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_StartFrame;
  logic       Rx_NewByte;
  logic [7:0] Rx_Data;
  logic       Rx_EndFrame;
  logic       Rx_FrameError;

  modport master (
    output Rx, RxEN,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_StartFrame,
    input  Rx_NewByte, Rx_Data, Rx_EndFrame, Rx_FrameError
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_StartFrame,
    output Rx_NewByte, Rx_Data, Rx_EndFrame, Rx_FrameError
  );

endinterface

// File: rtl/hdlc_rx_deframer_flag_detect.sv
// hdlc_rx_flag_detect: raw 8-bit window over the Rx line, flag and abort
// detection, and the delayed data-bit stream fed to the destuffer.
//   Clk, Rst  : clock, synchronous active-high reset
//   RxEN, Rx  : bit strobe and serial bit
//   flagHit   : window equals 0x7E after this shift (combinational)
//   abortHit  : this bit is the 7th consecutive 1 (combinational)
//   dBitValid : dBit is a frame data bit on this edge (combinational)
//   dBit      : delayed data bit
import hdlc_pkg::*;

module hdlc_rx_flag_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic RxEN,
  input  logic Rx,
  output logic flagHit,
  output logic abortHit,
  output logic dBitValid,
  output logic dBit
);

  logic [7:0] window, windowNext;
  logic [2:0] onesCnt, onesNext;
  logic [3:0] validCnt, validNext;
  logic       flagMatch;

  // Once the post-shift count reaches 8 the whole window is frame data and
  // W[0] is released; it already has 7 newer bits behind it, enough to rule
  // out it starting a flag or abort. The bit released on an abort edge is
  // still data; on a flag edge W[0] is the flag's own first bit.
  always_comb begin
    windowNext = {Rx, window[7:1]};
    flagMatch  = (windowNext == FLAG_PATTERN);
    flagHit    = RxEN && flagMatch;
    abortHit   = RxEN && Rx && (onesCnt == ABORT_RUN - 3'd1);
    onesNext   = Rx ? ((onesCnt == ABORT_RUN) ? onesCnt : onesCnt + 3'd1) : '0;
    if (flagHit || abortHit) begin
      validNext = '0;
    end else begin
      validNext = (validCnt == 4'd8) ? validCnt : validCnt + 4'd1;
    end
    dBitValid  = RxEN && !flagMatch && (validCnt >= 4'd7);
    dBit       = windowNext[0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      window   <= '0;
      onesCnt  <= '0;
      validCnt <= '0;
    end else if (RxEN) begin
      window   <= windowNext;
      onesCnt  <= onesNext;
      validCnt <= validNext;
    end
  end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC receive deframer top level. Destuffs the delayed bit
// stream, assembles LSB-first bytes and runs the HUNT/FLAG/FRAME machine.
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   rxIf : slave side of hdlc_rx_deframer_if (Rx/RxEN in, events/data out)
// Parameter MIN_BYTES: minimum bytes for an error-free frame.
import hdlc_pkg::*;

module hdlc_rx_deframer #(
  parameter int unsigned MIN_BYTES = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  hdlc_rx_deframer_if.slave   rxIf
);

  logic flagHit, abortHit, dBitValid, dBit;

  hdlc_rx_flag_detect u_flagDetect (
    .Clk       (Clk),
    .Rst       (Rst),
    .RxEN      (rxIf.RxEN),
    .Rx        (rxIf.Rx),
    .flagHit   (flagHit),
    .abortHit  (abortHit),
    .dBitValid (dBitValid),
    .dBit      (dBit)
  );

  rx_state_t  state, stateNext;
  logic       validFrame, validFrameNext;
  logic       flagDetect, flagDetectNext;
  logic       abortDetect, abortDetectNext;
  logic       startFrame, startFrameNext;
  logic       newByte, newByteNext;
  logic       endFrame, endFrameNext;
  logic       frameError, frameErrorNext;
  logic [7:0] dataReg, dataNext;
  logic [7:0] shiftReg, shiftNext;
  logic [2:0] bitCnt, bitNext;
  logic [7:0] byteCnt, byteNext;
  logic [2:0] stuffCnt, stuffNext;
  logic       keepBit, assembleEn, byteDone;

  always_comb begin
    stateNext       = state;
    validFrameNext  = validFrame;
    flagDetectNext  = 1'b0;
    abortDetectNext = 1'b0;
    startFrameNext  = 1'b0;
    newByteNext     = 1'b0;
    endFrameNext    = 1'b0;
    frameErrorNext  = 1'b0;
    dataNext        = dataReg;
    shiftNext       = shiftReg;
    bitNext         = bitCnt;
    byteNext        = byteCnt;
    stuffNext       = stuffCnt;

    keepBit    = dBitValid && !(!dBit && (stuffCnt == STUFF_RUN));
    assembleEn = keepBit && ((state == FRAME) || ((state == FLAG) && !abortHit));
    byteDone   = assembleEn && (bitCnt == 3'd7);

    if (dBitValid) begin
      stuffNext = dBit ? ((stuffCnt == 3'd7) ? stuffCnt : stuffCnt + 3'd1) : '0;
    end

    if (assembleEn) begin
      shiftNext = {dBit, shiftReg[7:1]};
      bitNext   = bitCnt + 3'd1;
      if (byteDone) begin
        dataNext       = {dBit, shiftReg[7:1]};
        newByteNext    = 1'b1;
        startFrameNext = (byteCnt == '0);
        byteNext       = (byteCnt == 8'hFF) ? byteCnt : byteCnt + 8'd1;
      end
    end

    case (state)
      HUNT: begin
        if (flagHit) begin
          stateNext      = FLAG;
          flagDetectNext = 1'b1;
        end
      end
      FLAG: begin
        if (flagHit) begin
          flagDetectNext = 1'b1;
        end else if (abortHit) begin
          stateNext = HUNT;
        end else if (dBitValid) begin
          stateNext      = FRAME;
          validFrameNext = 1'b1;
        end
      end
      FRAME: begin
        if (flagHit) begin
          stateNext      = FLAG;
          flagDetectNext = 1'b1;
          endFrameNext   = 1'b1;
          validFrameNext = 1'b0;
          frameErrorNext = (bitCnt != '0) || (32'(byteCnt) < MIN_BYTES);
        end else if (abortHit) begin
          stateNext       = HUNT;
          abortDetectNext = 1'b1;
          validFrameNext  = 1'b0;
        end
      end
      default: stateNext = HUNT;
    endcase

    // Delimiters restart the frame bookkeeping; a byte finished by the last
    // data bit on an abort edge has already been reported above.
    if (flagHit || abortHit) begin
      shiftNext = '0;
      bitNext   = '0;
      byteNext  = '0;
      stuffNext = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= HUNT;
      validFrame  <= 1'b0;
      flagDetect  <= 1'b0;
      abortDetect <= 1'b0;
      startFrame  <= 1'b0;
      newByte     <= 1'b0;
      endFrame    <= 1'b0;
      frameError  <= 1'b0;
      dataReg     <= '0;
      shiftReg    <= '0;
      bitCnt      <= '0;
      byteCnt     <= '0;
      stuffCnt    <= '0;
    end else begin
      state       <= stateNext;
      validFrame  <= validFrameNext;
      flagDetect  <= flagDetectNext;
      abortDetect <= abortDetectNext;
      startFrame  <= startFrameNext;
      newByte     <= newByteNext;
      endFrame    <= endFrameNext;
      frameError  <= frameErrorNext;
      dataReg     <= dataNext;
      shiftReg    <= shiftNext;
      bitCnt      <= bitNext;
      byteCnt     <= byteNext;
      stuffCnt    <= stuffNext;
    end
  end

  assign rxIf.Rx_FlagDetect  = flagDetect;
  assign rxIf.Rx_AbortDetect = abortDetect;
  assign rxIf.Rx_ValidFrame  = validFrame;
  assign rxIf.Rx_StartFrame  = startFrame;
  assign rxIf.Rx_NewByte     = newByte;
  assign rxIf.Rx_Data        = dataReg;
  assign rxIf.Rx_EndFrame    = endFrame;
  assign rxIf.Rx_FrameError  = frameError;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: directed bench for hdlc_rx_deframer. Two instances
// share the Rx line: dut1 with MIN_BYTES=1, dut2 with MIN_BYTES=2.
module tb_hdlc_rx_deframer;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic rxEn;

  always #5 clk = ~clk;

  hdlc_rx_deframer_if rxIf1 ();
  hdlc_rx_deframer_if rxIf2 ();

  assign rxIf1.Rx   = rx;
  assign rxIf1.RxEN = rxEn;
  assign rxIf2.Rx   = rx;
  assign rxIf2.RxEN = rxEn;

  hdlc_rx_deframer #(.MIN_BYTES(1)) dut1 (.Clk(clk), .Rst(rst), .rxIf(rxIf1));
  hdlc_rx_deframer #(.MIN_BYTES(2)) dut2 (.Clk(clk), .Rst(rst), .rxIf(rxIf2));

  int checks   = 0;
  int failures = 0;

  int         flagCnt, abortCnt, newByteCnt, startCnt, startOnFirst;
  int         endCnt, errCnt, end2Cnt, err2Cnt, idlePulseCnt;
  logic [7:0] byteLog [16];
  bit         toggleMode;

  task automatic checkEq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] outs1();
    return {rxIf1.Rx_FlagDetect, rxIf1.Rx_AbortDetect, rxIf1.Rx_ValidFrame,
            rxIf1.Rx_StartFrame, rxIf1.Rx_NewByte, rxIf1.Rx_EndFrame,
            rxIf1.Rx_FrameError, rxIf1.Rx_Data};
  endfunction

  function automatic logic [14:0] outs2();
    return {rxIf2.Rx_FlagDetect, rxIf2.Rx_AbortDetect, rxIf2.Rx_ValidFrame,
            rxIf2.Rx_StartFrame, rxIf2.Rx_NewByte, rxIf2.Rx_EndFrame,
            rxIf2.Rx_FrameError, rxIf2.Rx_Data};
  endfunction

  task automatic clearStats();
    flagCnt = 0; abortCnt = 0; newByteCnt = 0; startCnt = 0; startOnFirst = 0;
    endCnt = 0; errCnt = 0; end2Cnt = 0; err2Cnt = 0; idlePulseCnt = 0;
    for (int i = 0; i < 16; i++) byteLog[i] = 8'h00;
  endtask

  // One clock: wait for the edge, sample 1 time unit later, log events.
  task automatic tick();
    logic enAtEdge;
    enAtEdge = rxEn;
    @(posedge clk);
    #1;
    if (rxIf1.Rx_FlagDetect)  flagCnt++;
    if (rxIf1.Rx_AbortDetect) abortCnt++;
    if (rxIf1.Rx_StartFrame)  startCnt++;
    if (rxIf1.Rx_NewByte) begin
      if (newByteCnt < 16) byteLog[newByteCnt] = rxIf1.Rx_Data;
      if (rxIf1.Rx_StartFrame && newByteCnt == 0) startOnFirst++;
      newByteCnt++;
    end
    if (rxIf1.Rx_EndFrame)   endCnt++;
    if (rxIf1.Rx_FrameError) errCnt++;
    if (rxIf2.Rx_EndFrame)   end2Cnt++;
    if (rxIf2.Rx_FrameError) err2Cnt++;
    if (!enAtEdge && (rxIf1.Rx_FlagDetect || rxIf1.Rx_AbortDetect || rxIf1.Rx_StartFrame ||
                      rxIf1.Rx_NewByte || rxIf1.Rx_EndFrame || rxIf1.Rx_FrameError))
      idlePulseCnt++;
  endtask

  task automatic sendBit(input logic b);
    rx   = b;
    rxEn = 1'b1;
    tick();
    if (toggleMode) begin
      rxEn = 1'b0;
      rx   = ~b;
      tick();
    end
  endtask

  task automatic sendBits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) sendBit(v[i]);
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendBit(v[i]);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    rxEn = 1'b0;
    rx   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clearStats();
  endtask

  initial begin
    toggleMode = 1'b0;
    clearStats();
    rst  = 1'b1;
    rx   = 1'b0;
    rxEn = 1'b1;
    tick();
    tick();
    checkEq("reset_outs1", int'(outs1()), 0);
    checkEq("reset_outs2", int'(outs2()), 0);
    rst = 1'b0;
    clearStats();

    // Two-byte frame
    sendByte(8'h7E);
    sendByte(8'hA5);
    checkEq("t1_valid_mid", int'(rxIf1.Rx_ValidFrame), 1);
    sendByte(8'h3C);
    sendByte(8'h7E);
    checkEq("t1_nbytes", newByteCnt, 2);
    checkEq("t1_byte0", int'(byteLog[0]), 'hA5);
    checkEq("t1_byte1", int'(byteLog[1]), 'h3C);
    checkEq("t1_start", startCnt, 1);
    checkEq("t1_start_first", startOnFirst, 1);
    checkEq("t1_end", endCnt, 1);
    checkEq("t1_err", errCnt, 0);
    checkEq("t1_err_min2", err2Cnt, 0);
    checkEq("t1_flags", flagCnt, 2);
    checkEq("t1_abort", abortCnt, 0);
    checkEq("t1_valid_end", int'(rxIf1.Rx_ValidFrame), 0);

    // 0xFF with a stuffed zero on the line
    doReset();
    sendByte(8'h7E);
    sendBits(16'h01DF, 9);
    sendByte(8'h7E);
    checkEq("t2_nbytes", newByteCnt, 1);
    checkEq("t2_byte0", int'(byteLog[0]), 'hFF);
    checkEq("t2_abort", abortCnt, 0);
    checkEq("t2_end", endCnt, 1);
    checkEq("t2_err", errCnt, 0);

    // Abort after one byte, then recovery
    doReset();
    sendByte(8'h7E);
    sendByte(8'h12);
    sendBits(16'h007F, 7);
    checkEq("t3_nbytes", newByteCnt, 1);
    checkEq("t3_byte0", int'(byteLog[0]), 'h12);
    checkEq("t3_abort", abortCnt, 1);
    checkEq("t3_end", endCnt, 0);
    checkEq("t3_valid", int'(rxIf1.Rx_ValidFrame), 0);
    sendByte(8'h7E);
    checkEq("t3_flags", flagCnt, 2);
    sendByte(8'hA5);
    sendByte(8'h7E);
    checkEq("t3_nbytes_after", newByteCnt, 2);
    checkEq("t3_byte1", int'(byteLog[1]), 'hA5);
    checkEq("t3_end_after", endCnt, 1);
    checkEq("t3_err_after", errCnt, 0);
    checkEq("t3_start_after", startCnt, 2);

    // Partial byte before closing flag
    doReset();
    sendByte(8'h7E);
    sendByte(8'hA5);
    sendBits(16'h0005, 3);
    sendByte(8'h7E);
    checkEq("t4_nbytes", newByteCnt, 1);
    checkEq("t4_end", endCnt, 1);
    checkEq("t4_err", errCnt, 1);
    checkEq("t4_err_min2", err2Cnt, 1);

    // One-byte frame: good with MIN_BYTES=1, short with MIN_BYTES=2
    doReset();
    sendByte(8'h7E);
    sendByte(8'hA5);
    sendByte(8'h7E);
    checkEq("t4b_end", endCnt, 1);
    checkEq("t4b_err", errCnt, 0);
    checkEq("t4b_end_min2", end2Cnt, 1);
    checkEq("t4b_err_min2", err2Cnt, 1);

    // Back-to-back and shared-zero flags
    doReset();
    sendByte(8'h7E);
    sendByte(8'h7E);
    sendByte(8'h7E);
    sendBits(16'h3F7E, 15);
    checkEq("t5_flags", flagCnt, 5);
    checkEq("t5_nbytes", newByteCnt, 0);
    checkEq("t5_end", endCnt, 0);
    checkEq("t5_abort", abortCnt, 0);

    // RxEN alternating 1/0
    doReset();
    toggleMode = 1'b1;
    sendByte(8'h7E);
    sendByte(8'hA5);
    sendByte(8'h3C);
    sendByte(8'h7E);
    toggleMode = 1'b0;
    checkEq("t6_nbytes", newByteCnt, 2);
    checkEq("t6_byte0", int'(byteLog[0]), 'hA5);
    checkEq("t6_byte1", int'(byteLog[1]), 'h3C);
    checkEq("t6_end", endCnt, 1);
    checkEq("t6_err", errCnt, 0);
    checkEq("t6_flags", flagCnt, 2);
    checkEq("t6_idle_pulses", idlePulseCnt, 0);

    // Reset mid-byte, then a clean frame
    doReset();
    sendByte(8'h7E);
    sendByte(8'hA5);
    sendByte(8'h3C);
    sendBits(16'h005A, 4);
    checkEq("t7_valid_before", int'(rxIf1.Rx_ValidFrame), 1);
    checkEq("t7_data_before", int'(rxIf1.Rx_Data), 'hA5);
    rst  = 1'b1;
    rxEn = 1'b1;
    rx   = 1'b1;
    tick();
    checkEq("t7_rst_outs1", int'(outs1()), 0);
    checkEq("t7_rst_outs2", int'(outs2()), 0);
    rst = 1'b0;
    clearStats();
    sendByte(8'h7E);
    sendByte(8'h3C);
    sendByte(8'hA5);
    sendByte(8'h7E);
    checkEq("t7_nbytes", newByteCnt, 2);
    checkEq("t7_byte0", int'(byteLog[0]), 'h3C);
    checkEq("t7_byte1", int'(byteLog[1]), 'hA5);
    checkEq("t7_end", endCnt, 1);
    checkEq("t7_err", errCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
